// File: rtl/zl_dvb_s_ts_derand_pkg.sv
// Shared constants, FSM encoding and the PRBS advance helper for the DVB-S
// TS derandomizer and its companion randomizer.
package zl_dvb_s_ts_derand_pkg;

    localparam int DATA_W      = 8;
    localparam int TS_PKT_LEN  = 188;
    localparam int TS_GRP_PKTS = 8;
    localparam int POS_W       = $clog2(TS_PKT_LEN);
    localparam int IDX_W       = $clog2(TS_GRP_PKTS);

    localparam logic [DATA_W-1:0] TS_SYNC     = 8'h47;
    localparam logic [DATA_W-1:0] TS_SYNC_INV = 8'hB8;
    localparam logic [14:0]       PRBS_INIT   = 15'h4A80;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } derand_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] out;
        logic [14:0]       state;
    } prbs_adv_t;

    // State bit 14 is r1, bit 0 is r15; the first generated bit lands in the byte MSB.
    function automatic prbs_adv_t prbs_step8(input logic [14:0] s);
        prbs_adv_t  res;
        logic [14:0] r;
        logic        fb;
        r = s;
        res.out = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb         = r[1] ^ r[0];
            res.out[i] = fb;
            r          = {fb, r[14:1]};
        end
        res.state = r;
        return res;
    endfunction

endpackage

// File: rtl/zl_dvb_s_ts_derand_if.sv
// Byte-stream bundle around the derandomizer: randomized input side and
// packet-aligned output side, each with its own req/ack handshake.
interface zl_dvb_s_ts_derand_if;
    import zl_dvb_s_ts_derand_pkg::*;

    logic [DATA_W-1:0] data_in;
    logic              data_in_req;
    logic              data_in_ack;
    logic [DATA_W-1:0] data_out;
    logic              data_out_sop;
    logic              data_out_req;
    logic              data_out_ack;

    modport master (
        output data_in, data_in_req, data_out_ack,
        input  data_in_ack, data_out, data_out_sop, data_out_req
    );

    modport slave (
        input  data_in, data_in_req, data_out_ack,
        output data_in_ack, data_out, data_out_sop, data_out_req
    );

endinterface

// File: rtl/zl_dvb_s_prbs.sv
// 1+x^14+x^15 energy-dispersal generator: reload to the init word or advance
// eight steps; prbs_byte is the next eight output bits from the current state.
module zl_dvb_s_prbs
    import zl_dvb_s_ts_derand_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    output logic [DATA_W-1:0] prbs_byte
);

    logic [14:0] state_q;
    prbs_adv_t   adv;

    assign adv       = prbs_step8(state_q);
    assign prbs_byte = adv.out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= PRBS_INIT;
        end else if (load) begin
            state_q <= PRBS_INIT;
        end else if (step) begin
            state_q <= adv.state;
        end
    end

endmodule

// File: rtl/zl_dvb_s_ts_derand.sv
// DVB-S receive derandomizer: group sync acquisition/tracking, PRBS removal,
// sync byte restoration and a single output register with req/ack flow control.
module zl_dvb_s_ts_derand
    import zl_dvb_s_ts_derand_pkg::*;
#(
    parameter int SYNC_LOCK_CNT   = 3,
    parameter int SYNC_UNLOCK_CNT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    zl_dvb_s_ts_derand_if.slave bus,
    output logic                lock
);

    localparam int HIT_W  = $clog2(SYNC_LOCK_CNT + 1);
    localparam int MISS_W = $clog2(SYNC_UNLOCK_CNT + 1);

    derand_state_t     state;
    logic [POS_W-1:0]  byte_pos;
    logic [IDX_W-1:0]  pkt_idx;
    logic [HIT_W-1:0]  hit_cnt;
    logic [MISS_W-1:0] miss_cnt;

    logic [DATA_W-1:0] data_p1;
    logic              sop_p1;
    logic              vld_p1;

    logic              in_fire;
    logic              out_fire;
    logic              at_sync;
    logic              grp_start;
    logic              sync_ok;
    logic              seed;
    logic              hit_last;
    logic              miss_last;
    logic              pos_last;
    logic              emit;
    logic              prbs_load;
    logic              prbs_step;
    logic [DATA_W-1:0] sync_exp;
    logic [DATA_W-1:0] prbs_byte;
    logic [DATA_W-1:0] emit_data;

    assign bus.data_in_ack  = rst_n & (~vld_p1 | bus.data_out_ack);
    assign in_fire          = bus.data_in_req & bus.data_in_ack;
    assign out_fire         = vld_p1 & bus.data_out_ack;

    assign at_sync   = (byte_pos == '0);
    assign grp_start = at_sync && (pkt_idx == '0);
    assign sync_exp  = grp_start ? TS_SYNC_INV : TS_SYNC;
    assign sync_ok   = (bus.data_in == sync_exp);
    assign seed      = (state == ST_HUNT) && (bus.data_in == TS_SYNC_INV);
    assign hit_last  = (hit_cnt == HIT_W'(SYNC_LOCK_CNT - 1));
    assign miss_last = (miss_cnt == MISS_W'(SYNC_UNLOCK_CNT - 1));
    assign pos_last  = (byte_pos == POS_W'(TS_PKT_LEN - 1));

    // PRBS phase follows the counters, not the sync verdict.
    assign prbs_load = in_fire && (seed || ((state != ST_HUNT) && grp_start));
    assign prbs_step = in_fire && (state != ST_HUNT) && !grp_start;

    zl_dvb_s_prbs u_prbs (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (prbs_load),
        .step      (prbs_step),
        .prbs_byte (prbs_byte)
    );

    always_comb begin
        emit = 1'b0;
        case (state)
            ST_VERIFY: emit = at_sync && sync_ok && hit_last;
            ST_LOCKED: emit = !(at_sync && !sync_ok && miss_last);
            default:   emit = 1'b0;
        endcase
    end

    assign emit_data = at_sync ? TS_SYNC : (bus.data_in ^ prbs_byte);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_HUNT;
            byte_pos <= '0;
            pkt_idx  <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            lock     <= 1'b0;
        end else if (in_fire) begin
            if (state != ST_HUNT) begin
                byte_pos <= pos_last ? '0 : byte_pos + 1'b1;
                if (pos_last) begin
                    pkt_idx <= (pkt_idx == IDX_W'(TS_GRP_PKTS - 1)) ? '0 : pkt_idx + 1'b1;
                end
            end
            case (state)
                ST_HUNT: begin
                    if (seed) begin
                        state    <= ST_VERIFY;
                        byte_pos <= POS_W'(1);
                        pkt_idx  <= '0;
                        hit_cnt  <= HIT_W'(1);
                    end
                end
                ST_VERIFY: begin
                    if (at_sync) begin
                        if (!sync_ok) begin
                            state <= ST_HUNT;
                        end else begin
                            hit_cnt <= hit_cnt + 1'b1;
                            if (hit_last) begin
                                state    <= ST_LOCKED;
                                miss_cnt <= '0;
                                lock     <= 1'b1;
                            end
                        end
                    end
                end
                ST_LOCKED: begin
                    if (at_sync) begin
                        if (sync_ok) begin
                            miss_cnt <= '0;
                        end else begin
                            miss_cnt <= miss_cnt + 1'b1;
                            if (miss_last) begin
                                state <= ST_HUNT;
                                lock  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state <= ST_HUNT;
                    lock  <= 1'b0;
                end
            endcase
        end
    end

    // p1: output register, refilled only when empty or being drained
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            sop_p1  <= 1'b0;
        end else begin
            if (out_fire) begin
                vld_p1 <= 1'b0;
            end
            if (in_fire && emit) begin
                vld_p1  <= 1'b1;
                data_p1 <= emit_data;
                sop_p1  <= at_sync;
            end
        end
    end

    assign bus.data_out     = data_p1;
    assign bus.data_out_sop = sop_p1;
    assign bus.data_out_req = vld_p1;

endmodule

// File: tb/tb_zl_dvb_s_ts_derand.sv
// Scoreboard bench: a TX-side randomizer builds the channel stream from known
// plaintext; a sync-tracking model predicts which plaintext bytes come out.
module tb_zl_dvb_s_ts_derand;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic lock;

    zl_dvb_s_ts_derand_if bus ();

    zl_dvb_s_ts_derand dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .lock  (lock)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       sop;
        int         pkt;
        int         pos;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // transmit-side generator
    logic [1:15] g_r;
    int          g_pkt = 0;
    int          g_pos = 0;
    int          corrupt_left = 0;
    bit          raw_zero = 1'b0;
    bit          chk_prbs = 1'b0;

    logic [7:0] cur_w;
    logic [7:0] cur_p;
    int         cur_pkt;
    int         cur_pos;
    bit         have_cur = 1'b0;

    // receive-side sync model
    int m_st = 0;
    int m_pos = 0;
    int m_pidx = 0;
    int m_hit = 0;
    int m_miss = 0;
    bit exp_lock = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic prbs8(inout logic [1:15] r, output logic [7:0] b);
        logic o;
        for (int i = 0; i < 8; i++) begin
            o        = r[14] ^ r[15];
            b[7 - i] = o;
            r        = {o, r[1:14]};
        end
    endtask

    task automatic gen_byte();
        logic [7:0] pb;
        cur_pkt = g_pkt;
        cur_pos = g_pos;
        if (g_pos == 0) begin
            if (g_pkt == 0) begin
                g_r   = 15'b100101010000000;
                cur_w = 8'hB8;
            end else begin
                prbs8(g_r, pb);
                cur_w = 8'h47;
            end
            cur_p = 8'h47;
            if (corrupt_left > 0) begin
                cur_w = 8'h00;
                corrupt_left--;
            end
        end else begin
            prbs8(g_r, pb);
            if (raw_zero) begin
                cur_w = 8'h00;
                cur_p = pb;
            end else begin
                cur_p = 8'($urandom_range(255));
                if ((cur_p ^ pb) == 8'hB8) cur_p = cur_p ^ 8'h01;
                cur_w = cur_p ^ pb;
            end
        end
        g_pos++;
        if (g_pos == 188) begin
            g_pos = 0;
            g_pkt = (g_pkt + 1) % 8;
        end
        have_cur = 1'b1;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic s, input int pk, input int ps);
        exp_t e;
        e.data = d;
        e.sop  = s;
        e.pkt  = pk;
        e.pos  = ps;
        sb_q.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] w, input logic [7:0] p, input int pk, input int ps);
        logic [7:0] es;
        bit         at0;
        at0 = (m_pos == 0);
        es  = (m_pidx == 0) ? 8'hB8 : 8'h47;
        if (m_st == 0) begin
            if (w == 8'hB8) begin
                m_st   = 1;
                m_pos  = 1;
                m_pidx = 0;
                m_hit  = 1;
            end
        end else begin
            if (m_st == 1) begin
                if (at0) begin
                    if (w == es) begin
                        m_hit++;
                        if (m_hit == 3) begin
                            m_st   = 2;
                            m_miss = 0;
                            push_exp(8'h47, 1'b1, pk, ps);
                        end
                    end else begin
                        m_st = 0;
                    end
                end
            end else begin
                if (at0) begin
                    if (w == es) begin
                        m_miss = 0;
                        push_exp(8'h47, 1'b1, pk, ps);
                    end else begin
                        m_miss++;
                        if (m_miss == 4) m_st = 0;
                        else push_exp(8'h47, 1'b1, pk, ps);
                    end
                end else begin
                    push_exp(p, 1'b0, pk, ps);
                end
            end
            m_pos++;
            if (m_pos == 188) begin
                m_pos  = 0;
                m_pidx = (m_pidx + 1) % 8;
            end
        end
        exp_lock = (m_st == 2);
    endtask

    task automatic run_cycles(input int n, input int req_pct, input int ack_pct);
        logic out_req_s;
        logic ack;
        logic in_req;
        logic exp_in_ack;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            out_req_s = bus.data_out_req;
            check_eq("out_req", out_req_s, sb_q.size() != 0);
            check_eq("lock", lock, exp_lock);
            if (out_req_s && sb_q.size() != 0) begin
                check_eq("out_data", bus.data_out, sb_q[0].data);
                check_eq("out_sop", bus.data_out_sop, sb_q[0].sop);
                if (chk_prbs && !sb_q[0].sop && sb_q[0].pkt == 0 && sb_q[0].pos == 1)
                    check_eq("prbs_byte1", bus.data_out, 8'h03);
                if (chk_prbs && !sb_q[0].sop && sb_q[0].pkt == 0 && sb_q[0].pos == 2)
                    check_eq("prbs_byte2", bus.data_out, 8'hF6);
            end
            ack    = ($urandom_range(99) < ack_pct);
            in_req = ($urandom_range(99) < req_pct);
            if (!have_cur) gen_byte();
            bus.data_in      = cur_w;
            bus.data_in_req  = in_req;
            bus.data_out_ack = ack;
            if (out_req_s && ack && sb_q.size() != 0) void'(sb_q.pop_front());
            #1;
            exp_in_ack = rst_n & (~out_req_s | ack);
            check_eq("in_ack", bus.data_in_ack, exp_in_ack);
            if (in_req && exp_in_ack) begin
                model_byte(cur_w, cur_p, cur_pkt, cur_pos);
                have_cur = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n            = 1'b0;
        bus.data_in_req  = 1'b0;
        bus.data_out_ack = 1'b0;
        @(negedge clk);
        check_eq("rst_data", bus.data_out, 8'h00);
        check_eq("rst_sop", bus.data_out_sop, 1'b0);
        check_eq("rst_req", bus.data_out_req, 1'b0);
        check_eq("rst_lock", lock, 1'b0);
        check_eq("rst_in_ack", bus.data_in_ack, 1'b0);
        sb_q.delete();
        m_st     = 0;
        m_pos    = 0;
        m_pidx   = 0;
        m_hit    = 0;
        m_miss   = 0;
        exp_lock = 1'b0;
        rst_n    = 1'b1;
    endtask

    initial begin
        bus.data_in      = 8'h00;
        bus.data_in_req  = 1'b0;
        bus.data_out_ack = 1'b0;
        g_r              = 15'b100101010000000;
        repeat (3) @(negedge clk);
        do_reset();

        // all-zero channel payload exposes the raw PRBS after the group sync
        raw_zero = 1'b1;
        chk_prbs = 1'b1;
        run_cycles(8 * 188 + 400, 100, 100);
        chk_prbs = 1'b0;
        raw_zero = 1'b0;

        // random payload, full throughput
        run_cycles(3000, 100, 100);

        // lone corrupted sync while locked
        corrupt_left = 1;
        run_cycles(600, 100, 100);

        // four corrupted syncs in a row drop lock, relock on next group
        corrupt_left = 4;
        run_cycles(3200, 100, 100);

        // source gaps and sink stalls
        run_cycles(6000, 70, 60);

        // reset in the middle of a packet, then relock
        run_cycles(97, 100, 100);
        do_reset();
        run_cycles(2600, 100, 100);
        @(negedge clk);
        check_eq("relock_end", lock, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
